// File: rtl/vga_pkg.sv
// Shared VGA constants and the RGB565 -> RGB888 expansion used by the obstacle renderer.
package vga_pkg;
    localparam logic [23:0] BG_COLOR        = 24'h88CC88;
    localparam logic [15:0] TRANSPARENT_KEY = 16'hF81F;
    localparam int          SCREEN_W        = 640;
    localparam int          SCREEN_H        = 480;
    localparam int          PIPE_LAT        = 3;

    // Expand by replicating the top bits so full-scale 565 maps to full-scale 888.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] c);
        return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
    endfunction
endpackage

// File: rtl/obstacle_hit_prio.sv
// Per-slot window compare plus fixed-priority select (lowest slot wins); purely combinational.
module obstacle_hit_prio #(
    parameter int NUM_OBS = 4,
    parameter int SPAN_X  = 64,
    parameter int SPAN_Y  = 64
) (
    input  logic [9:0]           hcount,
    input  logic [9:0]           vcount,
    input  logic [10*NUM_OBS-1:0] x_sh,
    input  logic [10*NUM_OBS-1:0] y_sh,
    input  logic [NUM_OBS-1:0]   valid_sh,
    output logic                 hit,
    output logic [2:0]           slot,
    output logic [9:0]           dx,
    output logic [9:0]           dy
);
    logic [NUM_OBS-1:0] slot_hit;
    logic [9:0]         dx_slot [NUM_OBS];
    logic [9:0]         dy_slot [NUM_OBS];

    generate
        for (genvar gi = 0; gi < NUM_OBS; gi++) begin : g_slot
            logic [10:0] x0;
            logic [10:0] y0;
            assign x0 = {1'b0, x_sh[10*gi +: 10]};
            assign y0 = {1'b0, y_sh[10*gi +: 10]};
            // 11-bit window ends keep sprites near 1023 from wrapping to coordinate 0.
            assign slot_hit[gi] = valid_sh[gi]
                && ({1'b0, hcount} >= x0) && ({1'b0, hcount} < x0 + 11'(SPAN_X))
                && ({1'b0, vcount} >= y0) && ({1'b0, vcount} < y0 + 11'(SPAN_Y));
            assign dx_slot[gi] = hcount - x_sh[10*gi +: 10];
            assign dy_slot[gi] = vcount - y_sh[10*gi +: 10];
        end
    endgenerate

    always_comb begin
        hit  = 1'b0;
        slot = 3'd0;
        dx   = 10'd0;
        dy   = 10'd0;
        for (int i = NUM_OBS - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                hit  = 1'b1;
                slot = 3'(i);
                dx   = dx_slot[i];
                dy   = dy_slot[i];
            end
        end
    end
endmodule

// File: rtl/bitgen_obstacle_array.sv
// Three-stage multi-obstacle sprite renderer (hit/address, ROM read, colour).
// OBSTACLE_ANIM_EN enables the frame_tick-driven animation counter.
module bitgen_obstacle_array
    import vga_pkg::*;
#(
    parameter int          NUM_OBS       = 4,
    parameter int          SPRITE_WIDTH  = 32,
    parameter int          SPRITE_HEIGHT = 32,
    parameter int          SCALE_LOG2    = 1,
    parameter logic [12:0] BASE_ADDR     = 13'd4096,
    parameter int          NUM_FRAMES    = 2,
    parameter int          FRAME_DIV     = 8
) (
    input  logic                  pix_clk,
    input  logic                  rst_n,
    input  logic                  bright,
    input  logic [9:0]            hcount,
    input  logic [9:0]            vcount,
    input  logic                  frame_tick,
    input  logic [10*NUM_OBS-1:0] obs_x,
    input  logic [10*NUM_OBS-1:0] obs_y,
    input  logic [NUM_OBS-1:0]    obs_valid,
    output logic [12:0]           sprite_addr,
    input  logic [16:0]           sprite_data,
    output logic [7:0]            vga_r,
    output logic [7:0]            vga_g,
    output logic [7:0]            vga_b,
    output logic                  pixel_opaque,
    output logic [2:0]            hit_id
);
    localparam int SPAN_X = SPRITE_WIDTH << SCALE_LOG2;
    localparam int SPAN_Y = SPRITE_HEIGHT << SCALE_LOG2;

    logic [10*NUM_OBS-1:0] x_sh_q, y_sh_q;
    logic [NUM_OBS-1:0]    valid_sh_q;
    logic [12:0]           frame_base;

    // Positions only change at frame boundaries so a sprite never tears mid-frame.
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_sh_q     <= '0;
            y_sh_q     <= '0;
            valid_sh_q <= '0;
        end else if (frame_tick) begin
            x_sh_q     <= obs_x;
            y_sh_q     <= obs_y;
            valid_sh_q <= obs_valid;
        end
    end

`ifdef OBSTACLE_ANIM_EN
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int FRM_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    logic [DIV_W-1:0] div_cnt_q;
    logic [FRM_W-1:0] anim_frame_q;

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            anim_frame_q <= '0;
        end else if (frame_tick) begin
            if (int'(div_cnt_q) == FRAME_DIV - 1) begin
                div_cnt_q    <= '0;
                anim_frame_q <= (int'(anim_frame_q) == NUM_FRAMES - 1) ? '0 : anim_frame_q + FRM_W'(1);
            end else begin
                div_cnt_q <= div_cnt_q + DIV_W'(1);
            end
        end
    end
    assign frame_base = 13'(anim_frame_q) * 13'(SPRITE_WIDTH * SPRITE_HEIGHT);
`else
    assign frame_base = 13'd0;
`endif

    logic       hit;
    logic [2:0] slot;
    logic [9:0] dx, dy;

    obstacle_hit_prio #(
        .NUM_OBS (NUM_OBS),
        .SPAN_X  (SPAN_X),
        .SPAN_Y  (SPAN_Y)
    ) u_hit_prio (
        .hcount   (hcount),
        .vcount   (vcount),
        .x_sh     (x_sh_q),
        .y_sh     (y_sh_q),
        .valid_sh (valid_sh_q),
        .hit      (hit),
        .slot     (slot),
        .dx       (dx),
        .dy       (dy)
    );

    logic [12:0] addr_d, sprite_addr_q;
    logic        hit1_q, bright1_q, hit2_q, bright2_q;
    logic [2:0]  slot1_q, slot2_q;

    always_comb begin
        addr_d = BASE_ADDR;
        if (bright && hit)
            addr_d = BASE_ADDR + frame_base
                   + 13'(dy >> SCALE_LOG2) * 13'(SPRITE_WIDTH)
                   + 13'(dx >> SCALE_LOG2);
    end

    // Stage 1 registers the ROM address; stage 2 tracks the ROM read latency.
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            sprite_addr_q <= BASE_ADDR;
            hit1_q        <= 1'b0;
            slot1_q       <= 3'd0;
            bright1_q     <= 1'b0;
            hit2_q        <= 1'b0;
            slot2_q       <= 3'd0;
            bright2_q     <= 1'b0;
        end else begin
            sprite_addr_q <= addr_d;
            hit1_q        <= hit;
            slot1_q       <= slot;
            bright1_q     <= bright;
            hit2_q        <= hit1_q;
            slot2_q       <= slot1_q;
            bright2_q     <= bright1_q;
        end
    end
    assign sprite_addr = sprite_addr_q;

    logic [23:0] rgb_d, rgb_q;
    logic        opaque_d, opaque_q;
    logic [2:0]  hit_id_d, hit_id_q;
    logic        unused_bits;
    assign unused_bits = sprite_data[16];

    always_comb begin
        rgb_d    = 24'd0;
        opaque_d = 1'b0;
        hit_id_d = 3'd0;
        if (bright2_q) begin
            if (hit2_q && sprite_data[15:0] != TRANSPARENT_KEY) begin
                rgb_d    = rgb565_to_888(sprite_data[15:0]);
                opaque_d = 1'b1;
                hit_id_d = slot2_q;
            end else begin
                rgb_d = BG_COLOR;
            end
        end
    end

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q    <= 24'd0;
            opaque_q <= 1'b0;
            hit_id_q <= 3'd0;
        end else begin
            rgb_q    <= rgb_d;
            opaque_q <= opaque_d;
            hit_id_q <= hit_id_d;
        end
    end

    assign vga_r        = rgb_q[23:16];
    assign vga_g        = rgb_q[15:8];
    assign vga_b        = rgb_q[7:0];
    assign pixel_opaque = opaque_q;
    assign hit_id       = hit_id_q;
endmodule

// File: tb/tb_bitgen_obstacle_array.sv
// Directed bench for bitgen_obstacle_array with a synchronous sprite-ROM model.
module tb_bitgen_obstacle_array;
    localparam int NUM_OBS = 4;
`ifdef OBSTACLE_ANIM_EN
    localparam logic [12:0] ANIM_ADDR_2 = 13'd5120;
`else
    localparam logic [12:0] ANIM_ADDR_2 = 13'd4096;
`endif
    localparam logic [23:0] BG   = 24'h88CC88;
    localparam logic [23:0] RED  = 24'hFF0000;
    localparam logic [23:0] GRN  = 24'h00FF00;
    localparam logic [23:0] BLU  = 24'h0000FF;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  bright;
    logic [9:0]            hcount, vcount;
    logic                  frame_tick;
    logic [10*NUM_OBS-1:0] obs_x, obs_y;
    logic [NUM_OBS-1:0]    obs_valid;
    logic [12:0]           sprite_addr;
    logic [16:0]           sprite_data;
    logic [7:0]            vga_r, vga_g, vga_b;
    logic                  pixel_opaque;
    logic [2:0]            hit_id;

    logic [16:0] rom [0:8191];
    logic [12:0] addr_seen;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) sprite_data <= rom[sprite_addr];

    bitgen_obstacle_array #(
        .NUM_OBS (NUM_OBS), .SPRITE_WIDTH(32), .SPRITE_HEIGHT(32), .SCALE_LOG2(1),
        .BASE_ADDR(13'd4096), .NUM_FRAMES(2), .FRAME_DIV(2)
    ) dut (
        .pix_clk(clk), .rst_n(rst_n), .bright(bright), .hcount(hcount), .vcount(vcount),
        .frame_tick(frame_tick), .obs_x(obs_x), .obs_y(obs_y), .obs_valid(obs_valid),
        .sprite_addr(sprite_addr), .sprite_data(sprite_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .pixel_opaque(pixel_opaque), .hit_id(hit_id)
    );

    task automatic set_slot(input int i, input logic [9:0] x, input logic [9:0] y);
        obs_x[10*i +: 10] = x;
        obs_y[10*i +: 10] = y;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    // Holds one pixel steady; records the address after one edge, returns after the third.
    task automatic run_pixel(input logic [9:0] h, input logic [9:0] v, input logic b);
        hcount = h; vcount = v; bright = b;
        @(posedge clk); #1;
        addr_seen = sprite_addr;
        @(posedge clk); @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (sprite_addr !== 13'd4096) begin errors++; $display("FAIL reset_addr: got %0d expected 4096", sprite_addr); end
        checks++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h expected 000000", {vga_r, vga_g, vga_b}); end
        checks++; if (pixel_opaque !== 1'b0 || hit_id !== 3'd0) begin errors++; $display("FAIL reset_flags: got opaque=%b id=%0d expected 0/0", pixel_opaque, hit_id); end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("reset: addr=%0d rgb=%h", sprite_addr, {vga_r, vga_g, vga_b});
    endtask

    task automatic test_basic();
        set_slot(0, 10'd100, 10'd200);
        obs_valid = 4'b0001;
        pulse_tick();
        run_pixel(10'd101, 10'd201, 1'b1);
        $display("basic (101,201): addr=%0d rgb=%h op=%b id=%0d", addr_seen, {vga_r, vga_g, vga_b}, pixel_opaque, hit_id);
        checks++; if (addr_seen !== 13'd4096) begin errors++; $display("FAIL basic_addr: got %0d expected 4096", addr_seen); end
        checks++; if ({vga_r, vga_g, vga_b} !== RED) begin errors++; $display("FAIL basic_rgb: got %h expected %h", {vga_r, vga_g, vga_b}, RED); end
        checks++; if (pixel_opaque !== 1'b1 || hit_id !== 3'd0) begin errors++; $display("FAIL basic_flags: got opaque=%b id=%0d expected 1/0", pixel_opaque, hit_id); end
        run_pixel(10'd163, 10'd263, 1'b1);
        $display("basic (163,263): addr=%0d op=%b", addr_seen, pixel_opaque);
        checks++; if (addr_seen !== 13'd5119) begin errors++; $display("FAIL basic_last_texel_addr: got %0d expected 5119", addr_seen); end
        checks++; if ({vga_r, vga_g, vga_b} !== BLU || pixel_opaque !== 1'b1) begin errors++; $display("FAIL basic_last_texel: got %h op=%b expected %h op=1", {vga_r, vga_g, vga_b}, pixel_opaque, BLU); end
        run_pixel(10'd164, 10'd201, 1'b1);
        $display("basic (164,201): addr=%0d rgb=%h op=%b", addr_seen, {vga_r, vga_g, vga_b}, pixel_opaque);
        checks++; if (addr_seen !== 13'd4096 || {vga_r, vga_g, vga_b} !== BG || pixel_opaque !== 1'b0) begin errors++; $display("FAIL basic_right_edge: got addr=%0d rgb=%h op=%b expected 4096 %h 0", addr_seen, {vga_r, vga_g, vga_b}, pixel_opaque, BG); end
    endtask

    task automatic test_overlap();
        set_slot(1, 10'd300, 10'd100);
        set_slot(2, 10'd300, 10'd100);
        obs_valid = 4'b0111;
        pulse_tick();
        rom[4261] = 17'h007E0;
        run_pixel(10'd310, 10'd110, 1'b1);
        $display("overlap opaque: addr=%0d rgb=%h op=%b id=%0d", addr_seen, {vga_r, vga_g, vga_b}, pixel_opaque, hit_id);
        checks++; if (addr_seen !== 13'd4261) begin errors++; $display("FAIL overlap_addr: got %0d expected 4261", addr_seen); end
        checks++; if ({vga_r, vga_g, vga_b} !== GRN || pixel_opaque !== 1'b1 || hit_id !== 3'd1) begin errors++; $display("FAIL overlap_prio: got %h op=%b id=%0d expected %h 1 1", {vga_r, vga_g, vga_b}, pixel_opaque, hit_id, GRN); end
        rom[4261] = 17'h0F81F;
        run_pixel(10'd310, 10'd110, 1'b1);
        $display("overlap transparent: rgb=%h op=%b id=%0d", {vga_r, vga_g, vga_b}, pixel_opaque, hit_id);
        checks++; if ({vga_r, vga_g, vga_b} !== BG || pixel_opaque !== 1'b0 || hit_id !== 3'd0) begin errors++; $display("FAIL overlap_transparent: got %h op=%b id=%0d expected %h 0 0", {vga_r, vga_g, vga_b}, pixel_opaque, hit_id, BG); end
    endtask

    task automatic test_shadow();
        set_slot(0, 10'd400, 10'd200);
        run_pixel(10'd101, 10'd201, 1'b1);
        $display("shadow old pos: rgb=%h op=%b", {vga_r, vga_g, vga_b}, pixel_opaque);
        checks++; if ({vga_r, vga_g, vga_b} !== RED || pixel_opaque !== 1'b1) begin errors++; $display("FAIL shadow_hold: got %h op=%b expected %h 1", {vga_r, vga_g, vga_b}, pixel_opaque, RED); end
        run_pixel(10'd401, 10'd201, 1'b1);
        $display("shadow new pos pre-tick: op=%b", pixel_opaque);
        checks++; if (pixel_opaque !== 1'b0 || {vga_r, vga_g, vga_b} !== BG) begin errors++; $display("FAIL shadow_no_early: got %h op=%b expected %h 0", {vga_r, vga_g, vga_b}, pixel_opaque, BG); end
        pulse_tick();
        run_pixel(10'd401, 10'd201, 1'b1);
        $display("shadow new pos post-tick: rgb=%h op=%b", {vga_r, vga_g, vga_b}, pixel_opaque);
        checks++; if ({vga_r, vga_g, vga_b} !== RED || pixel_opaque !== 1'b1) begin errors++; $display("FAIL shadow_update: got %h op=%b expected %h 1", {vga_r, vga_g, vga_b}, pixel_opaque, RED); end
        run_pixel(10'd101, 10'd201, 1'b1);
        checks++; if (pixel_opaque !== 1'b0) begin errors++; $display("FAIL shadow_old_gone: got op=%b expected 0", pixel_opaque); end
    endtask

    task automatic test_edges();
        set_slot(0, 10'd620, 10'd200);
        obs_valid = 4'b0001;
        pulse_tick();
        run_pixel(10'd639, 10'd201, 1'b1);
        $display("edge (639,201): addr=%0d rgb=%h op=%b", addr_seen, {vga_r, vga_g, vga_b}, pixel_opaque);
        checks++; if (addr_seen !== 13'd4105 || {vga_r, vga_g, vga_b} !== BLU || pixel_opaque !== 1'b1) begin errors++; $display("FAIL edge_639: got addr=%0d %h op=%b expected 4105 %h 1", addr_seen, {vga_r, vga_g, vga_b}, pixel_opaque, BLU); end
        run_pixel(10'd0, 10'd201, 1'b1);
        checks++; if (pixel_opaque !== 1'b0 || addr_seen !== 13'd4096) begin errors++; $display("FAIL edge_no_wrap0: got addr=%0d op=%b expected 4096 0", addr_seen, pixel_opaque); end
        set_slot(0, 10'd1000, 10'd200);
        pulse_tick();
        run_pixel(10'd1010, 10'd201, 1'b1);
        $display("edge x=1000 (1010,201): addr=%0d op=%b", addr_seen, pixel_opaque);
        checks++; if (addr_seen !== 13'd4101 || pixel_opaque !== 1'b1) begin errors++; $display("FAIL edge_11bit_compare: got addr=%0d op=%b expected 4101 1", addr_seen, pixel_opaque); end
        run_pixel(10'd1010, 10'd201, 1'b0);
        $display("edge bright=0: addr=%0d rgb=%h op=%b", addr_seen, {vga_r, vga_g, vga_b}, pixel_opaque);
        checks++; if (addr_seen !== 13'd4096 || {vga_r, vga_g, vga_b} !== 24'h0 || pixel_opaque !== 1'b0 || hit_id !== 3'd0) begin errors++; $display("FAIL blank: got addr=%0d %h op=%b id=%0d expected 4096 000000 0 0", addr_seen, {vga_r, vga_g, vga_b}, pixel_opaque, hit_id); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_rgb [4];
        exp_rgb[0] = RED; exp_rgb[1] = RED; exp_rgb[2] = BLU; exp_rgb[3] = BLU;
        set_slot(0, 10'd100, 10'd200);
        pulse_tick();
        for (int k = 0; k < 6; k++) begin
            hcount = 10'(100 + k); vcount = 10'd201; bright = (k < 4);
            @(posedge clk); #1;
            if (k >= 2) begin
                $display("b2b pixel %0d: rgb=%h op=%b", k - 2, {vga_r, vga_g, vga_b}, pixel_opaque);
                checks++;
                if ({vga_r, vga_g, vga_b} !== exp_rgb[k-2] || pixel_opaque !== 1'b1) begin
                    errors++; $display("FAIL b2b_pixel%0d: got %h op=%b expected %h 1", k - 2, {vga_r, vga_g, vga_b}, pixel_opaque, exp_rgb[k-2]);
                end
            end
        end
    endtask

    task automatic test_reset_midline();
        run_pixel(10'd101, 10'd201, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        $display("async reset: addr=%0d rgb=%h op=%b", sprite_addr, {vga_r, vga_g, vga_b}, pixel_opaque);
        checks++; if (sprite_addr !== 13'd4096 || {vga_r, vga_g, vga_b} !== 24'h0 || pixel_opaque !== 1'b0) begin errors++; $display("FAIL async_reset: got addr=%0d %h op=%b expected 4096 000000 0", sprite_addr, {vga_r, vga_g, vga_b}, pixel_opaque); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin errors++; $display("FAIL reset_black_hold: got %h expected 000000", {vga_r, vga_g, vga_b}); end
        @(posedge clk); #1;
        $display("post-reset first pixel: rgb=%h op=%b", {vga_r, vga_g, vga_b}, pixel_opaque);
        checks++; if ({vga_r, vga_g, vga_b} !== BG || pixel_opaque !== 1'b0) begin errors++; $display("FAIL reset_first_pixel: got %h op=%b expected %h 0", {vga_r, vga_g, vga_b}, pixel_opaque, BG); end
    endtask

    task automatic test_anim();
        set_slot(0, 10'd100, 10'd200);
        obs_valid = 4'b0001;
        pulse_tick();
        pulse_tick();
        run_pixel(10'd100, 10'd200, 1'b1);
        $display("anim after 2 ticks: addr=%0d", addr_seen);
        checks++; if (addr_seen !== ANIM_ADDR_2) begin errors++; $display("FAIL anim_2ticks: got %0d expected %0d", addr_seen, ANIM_ADDR_2); end
        pulse_tick();
        pulse_tick();
        run_pixel(10'd100, 10'd200, 1'b1);
        $display("anim after 4 ticks: addr=%0d", addr_seen);
        checks++; if (addr_seen !== 13'd4096) begin errors++; $display("FAIL anim_4ticks: got %0d expected 4096", addr_seen); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8192; i++) rom[i] = 17'h0001F;
        rom[4096] = 17'h0F800;
        rst_n = 1'b0; bright = 1'b0; hcount = '0; vcount = '0; frame_tick = 1'b0;
        obs_x = '0; obs_y = '0; obs_valid = '0;
        test_reset();
        test_basic();
        test_overlap();
        test_shadow();
        test_edges();
        test_back_to_back();
        test_reset_midline();
        test_anim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bitgen_obstacle_array.md
# bitgen_obstacle_array

Pipelined renderer for up to `NUM_OBS` obstacle sprites, with per-obstacle X/Y positions and a frame-synchronous animation counter. It sits between game logic and the VGA pixel mux. It replaces the single-obstacle combinational bitgen. It drives one synchronous sprite-ROM port and returns RGB888 plus an opacity flag a fixed `PIPE_LAT` cycles after `hcount`/`vcount`.

## Interface
- `NUM_OBS`, 4: number of obstacle slots (1–8).
- `SPRITE_WIDTH`, 32: source sprite width in texels.
- `SPRITE_HEIGHT`, 32: source sprite height in texels.
- `SCALE_LOG2`, 1: on-screen scale is 2^SCALE_LOG2 (shift, no divider).
- `BASE_ADDR`, 13'd4096: ROM address of animation frame 0.
- `NUM_FRAMES`, 2: animation frames, stored contiguously at `SPRITE_WIDTH*SPRITE_HEIGHT` stride.
- `FRAME_DIV`, 8: number of `frame_tick` pulses per animation step (≥1).
- `pix_clk`  in  1  pixel clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `bright`  in  1  active-video flag, aligned with `hcount`/`vcount`.
- `hcount`, `vcount`  in  10 each  current pixel coordinates.
- `frame_tick`  in  1  one-cycle pulse at start of vertical blank.
- `obs_x`  in  10*NUM_OBS  packed X per slot; slot i at [10i+9:10i].
- `obs_y`  in  10*NUM_OBS  packed Y per slot.
- `obs_valid`  in  NUM_OBS  slot enable.
- `sprite_addr`  out  13  ROM read address (registered).
- `sprite_data`  in  17  ROM data; valid one cycle after address.
- `vga_r`, `vga_g`, `vga_b`  out  8 each  pixel colour.
- `pixel_opaque`  out  1  1 = sprite texel drawn.
- `hit_id`  out  3  slot index of drawn texel; 0 when not opaque.

## Operation
- **Shadow registers:** on `frame_tick`, latch `obs_x`, `obs_y`, `obs_valid` into shadow registers. Rendering uses only shadow copies, so positions never tear mid-frame. Reset clears `valid_sh` to 0.
- **Hit test (stage 1):** slot i hits when `valid_sh[i]`, hcount ∈ [x, x+W·S) and vcount ∈ [y, y+H·S).
  - Compare in 11 bits so that x+W·S > 1023 does not wrap. Sprites clip at the screen edge without wrap-around.
  - Lowest index wins on overlap.
  - There is no fall-through to the next slot when the winning texel is transparent; a single ROM port is used.
- **Address:** `BASE_ADDR + frame·W·H + ((vcount−y)>>SCALE_LOG2)·W + ((hcount−x)>>SCALE_LOG2)`, truncated to 13 bits.
  - Registered into `sprite_addr` together with hit, slot index and `bright`.
  - No hit or `bright`=0: `sprite_addr`=`BASE_ADDR`.
- **Colour (stage 3):** convert RGB565 to RGB888 by bit replication (r={r5,r5[4:2]}, g={g6,g6[5:4]}, b={b5,b5[4:2]}). `sprite_data[15:0]`==16'hF81F means transparent.
- **Output rules:**
  - `bright`=0: RGB 0, opaque 0.
  - Bright with no hit, or with a transparent texel: RGB 88/CC/88, opaque 0.
  - Bright with a hit and an opaque texel: texel colour, opaque 1, `hit_id` = slot index.
- **Animation:**
  - `div_cnt` counts `frame_tick` pulses, 0..FRAME_DIV−1.
  - On wrap, `anim_frame` advances 0..NUM_FRAMES−1 and then wraps to 0.
  - `frame_tick` asserted together with a mid-line pixel: the shadow latch and the counter update take effect for pixels sampled the following cycle.

## Timing
- `PIPE_LAT` = 3.
- Inputs sampled at edge t. `sprite_addr` is valid after t+1. ROM data is captured at t+2. `vga_*`, `pixel_opaque` and `hit_id` are valid after t+3.
- Downstream delays syncs by 3 cycles.
- Throughput: one pixel per cycle, no stalls.
- **Reset values:**
  - `sprite_addr`=`BASE_ADDR`.
  - `vga_*`=0, `pixel_opaque`=0, `hit_id`=0.
  - `anim_frame`=0, `div_cnt`=0.
  - Shadows=0.
  - All pipeline valid/bright bits are 0.
- Reset mid-frame: outputs go to reset values immediately (asynchronous). Output is black until 3 cycles after deassertion.

## Configuration
- `OBSTACLE_ANIM_EN`:
  - Defined: the animation counter is present as described.
  - Undefined: `anim_frame` is tied to 0, `div_cnt` is removed, and the address is always based on frame 0. `FRAME_DIV` and `NUM_FRAMES` are ignored.

## Structure
- **Shared package (`vga_pkg`):**
  - Background colour 24'h88CC88.
  - Transparent key 16'hF81F.
  - Screen dimensions 640/480.
  - `PIPE_LAT`.
  - An RGB565→888 conversion function.
- **Sub-module `obstacle_hit_prio`:** combinational per-slot compare plus fixed-priority encoder. Outputs hit, slot index and the selected x/y offsets.

## Test plan
- Slot 0 at (100,200), valid, S=2 (`SCALE_LOG2`=1), frame_tick issued; pixel (101,201) → after 3 cycles `sprite_addr` was 4096 at t+1, ROM texel 16'hF800 → RGB FF/00/00, opaque 1, hit_id 0.
- Slots 1 and 2 overlapping at (300,100); pixel inside both → `hit_id`=1. Transparent texel at slot 1 → background 88/CC/88, opaque 0.
- `obs_x` changed mid-frame without frame_tick → rendering unchanged until next frame_tick.
- `OBSTACLE_ANIM_EN` defined, FRAME_DIV=2, NUM_FRAMES=2: 2 ticks → address for texel (0,0) becomes 4096+1024=5120; 4 ticks → back to 4096.
- Slot at x=620 → pixels at hcount 620..639 drawn, no wrap to hcount 0. `bright`=0 → RGB 0, opaque 0.
- `rst_n` pulsed low mid-line → all outputs 0 asynchronously; first valid pixel 3 cycles after release.
